mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
// - Shares one single-port memory between the rv32i instruction-fetch port and its load/store port.
// - Sits between the core's mem_i_*/mem_d_* buses and the memory model or SRAM.
// - Accepts at most one outstanding request per port; round-robin on conflict; watchdog on a stalled memory.
// PARAMETERS
// - ADDR_W   32   address width, byte addressed
// - DATA_W   32   data width; mask width is DATA_W/8
// - TIMEOUT  255  max cycles in WAIT before abort; 0 disables the watchdog
// PORTS
// - clk          in   1        single clock, rising edge
// - rst          in   1        asynchronous, active-low reset
// - i_addr       in   ADDR_W   fetch address, sampled with i_rstrb
// - i_rstrb      in   1        fetch request (level sampled each cycle)
// - i_rdata      out  DATA_W   registered fetch data
// - i_rbusy      out  1        fetch request pending or in flight
// - d_addr       in   ADDR_W   load/store address
// - d_wdata      in   DATA_W   store data
// - d_wmask      in   DATA_W/8 store byte enables
// - d_rstrb      in   1        load request
// - d_wstrb      in   1        store request
// - d_rdata      out  DATA_W   registered load data
// - d_rbusy      out  1        load pending or in flight
// - d_wbusy      out  1        store pending or in flight
// - m_addr       out  ADDR_W   memory address
// - m_wdata      out  DATA_W   memory write data
// - m_wmask      out  DATA_W/8 memory byte enables
// - m_rstrb      out  1        one-cycle memory read strobe
// - m_wstrb      out  1        one-cycle memory write strobe
// - m_rdata      in   DATA_W   memory read data, valid in the first cycle m_rbusy=0 after m_rstrb
// - m_rbusy      in   1        memory read busy
// - m_wbusy      in   1        memory write busy
// - err          out  1        sticky watchdog-abort flag
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; i_rdata=d_rdata=0; all busy outputs, m_*strb and err=0; last_grant=D.
// - Capture: while a port is not pending, a strobe at edge E latches addr/wdata/wmask/kind and sets pending.
//   The matching busy output is high from E+1. Strobes while pending are ignored. d_wstrb&d_rstrb together: the store wins, the load is dropped.
// - IDLE: if any port is pending, grant it. If both are pending, grant the port not equal to last_grant.
//   In the grant cycle: drive m_addr/m_wdata/m_wmask from the latched copy, pulse m_rstrb or m_wstrb for exactly 1 cycle, then go to WAIT.
// - In IDLE, m_addr/m_wdata/m_wmask hold their last values; in WAIT they are held stable.
// - WAIT: completes at the first cycle with the relevant busy=0, no earlier than 1 cycle after the strobe.
//   On a read completion edge: capture m_rdata into i_rdata or d_rdata.
//   On any completion edge: clear that port's pending, set last_grant, return to IDLE.
// - Latency, zero-wait memory: strobe in cycle N, m_*strb in N+1, data registered at end of N+2, busy low in N+3.
//   A new grant may issue in N+3, so throughput is 1 access per 2 cycles.
// - Completion edge: the same port may re-request in that cycle and is captured, because pending clears on the same edge.
// - Watchdog: a counter (8+ bits, saturating) increments in WAIT.
//   When it reaches TIMEOUT: abort, set err, load 32'hDEADBEEF into the read-data register (reads only), clear pending, go to IDLE.
// - Mid-operation reset: the in-flight access is abandoned and strobes drop immediately; the memory must tolerate this.
// - rdata registers change only on a read completion of their own port.
// STRUCTURE
// - rv32i.vh: `ARB_IDLE, `ARB_WAIT state codes; `ARB_GNT_I / `ARB_GNT_D grant encodings; `ARB_ABORT_DATA (32'hDEADBEEF).
// - Sub-module arb_rr2: 2-way round-robin picker (req[1:0], last -> gnt[1:0]), purely combinational.
// - Top: per-port request latches, 2-state FSM, watchdog counter, output mux.
// TESTING
// - Lone fetch, 0-wait memory: i_rstrb pulse, addr 0x10, mem[0x10]=0x00100093.
//   Expect m_rstrb in N+1, i_rdata=0x00100093 and i_rbusy=0 in N+3.
// - Simultaneous d_rstrb@0x20 and i_rstrb@0x0, last_grant=D: fetch is served first, then the load; exactly two m_rstrb pulses.
// - Store 0xAABBCCDD, mask 4'b0100 @0x8: one m_wstrb with m_wmask=4'b0100.
//   A following load @0x8 returns 0x00BB0000 over a zeroed memory.
// - Memory holds m_rbusy=1 for 5 cycles: d_rbusy stays 1 throughout; d_rdata captured only on the 6th cycle; no second strobe.
// - TIMEOUT=4, m_rbusy stuck at 1: after 4 WAIT cycles, err=1, d_rdata=0xDEADBEEF, FSM returns to IDLE and serves a pending fetch.
// - Assert rst=0 during WAIT: all outputs reach reset values asynchronously; after release, a queued request is absent.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// State and grant encodings are visible to any checker that binds to the top.
package mem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        ARB_GNT_I = 1'b0,
        ARB_GNT_D = 1'b1
    } arb_gnt_t;

    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEADBEEF;

    // Watchdog counter width: at least 8 bits, wide enough to hold TIMEOUT.
    function automatic int wd_width(input int timeout);
        int w;
        w = 8;
        while ((64'd1 << w) <= 64'(timeout))
            w++;
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin picker: a lone request wins outright, on conflict the
// port that was not served last wins. Purely combinational.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,   // [0] fetch, [1] data
    input  logic       last,  // 1 when the data port was served last
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch port (i_*) and the load/store
// port (d_*): per-port request latches, round-robin grant, 2-state FSM, watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_rstrb,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_rbusy,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic                d_rstrb,
    input  logic                d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_rbusy,
    output logic                d_wbusy,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wmask,
    output logic                m_rstrb,
    output logic                m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rbusy,
    input  logic                m_wbusy,
    output logic                err,
    output logic                dbg_state
);

    localparam int MASK_W = DATA_W / 8;
    localparam int WD_W   = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Handshake: a strobe is sampled on any edge where its port is idle and
    // captured into a request latch; the port's busy output stays high from the
    // next cycle until the edge that completes or aborts the access.

    arb_state_t state, state_nxt;
    arb_gnt_t   last_grant, cur_port;
    logic       cur_write;

    logic              i_pend;
    logic [ADDR_W-1:0] i_addr_q;
    logic              d_pend, d_write_q;
    logic [ADDR_W-1:0] d_addr_q;
    logic [DATA_W-1:0] d_wdata_q;
    logic [MASK_W-1:0] d_wmask_q;

    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [MASK_W-1:0] m_wmask_q;
    logic [WD_W-1:0]   wd_cnt;

    logic [1:0] gnt;
    logic       grant, grant_d, done, abort, end_op, i_end, d_end, cur_busy;

    arb_rr2 u_rr2 (
        .req  ({d_pend, i_pend}),
        .last (last_grant == ARB_GNT_D),
        .gnt  (gnt)
    );

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        m_addr    = m_addr_q;
        m_wdata   = m_wdata_q;
        m_wmask   = m_wmask_q;
        m_rstrb   = 1'b0;
        m_wstrb   = 1'b0;
        cur_busy  = cur_write ? m_wbusy : m_rbusy;
        case (state)
            ARB_IDLE: begin
                if (gnt != 2'b00) begin
                    grant     = 1'b1;
                    grant_d   = gnt[1];
                    state_nxt = ARB_WAIT;
                    if (gnt[1]) begin
                        m_addr  = d_addr_q;
                        m_wdata = d_wdata_q;
                        m_wmask = d_wmask_q;
                        m_wstrb = d_write_q;
                        m_rstrb = ~d_write_q;
                    end else begin
                        m_addr  = i_addr_q;
                        m_wmask = '0;
                        m_rstrb = 1'b1;
                    end
                end
            end
            ARB_WAIT: begin
                if (!cur_busy) begin
                    done      = 1'b1;
                    state_nxt = ARB_IDLE;
                end else if (TIMEOUT > 0 && wd_cnt >= WD_LAST) begin
                    abort     = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign end_op    = done | abort;
    assign i_end     = end_op && (cur_port == ARB_GNT_I);
    assign d_end     = end_op && (cur_port == ARB_GNT_D);
    assign i_rbusy   = i_pend;
    assign d_rbusy   = d_pend & ~d_write_q;
    assign d_wbusy   = d_pend & d_write_q;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            last_grant <= ARB_GNT_D;
            cur_port   <= ARB_GNT_I;
            cur_write  <= 1'b0;
            wd_cnt     <= '0;
            err        <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_wmask_q  <= '0;
        end else begin
            state     <= state_nxt;
            m_addr_q  <= m_addr;
            m_wdata_q <= m_wdata;
            m_wmask_q <= m_wmask;
            if (grant) begin
                cur_port  <= grant_d ? ARB_GNT_D : ARB_GNT_I;
                cur_write <= grant_d & d_write_q;
                wd_cnt    <= '0;
            end else if (state == ARB_WAIT && !end_op && wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (end_op)
                last_grant <= cur_port;
            if (abort)
                err <= 1'b1;
        end
    end

    // Pending clears on the completion edge, so a strobe on that same edge is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_pend   <= 1'b0;
            i_addr_q <= '0;
            i_rdata  <= '0;
        end else begin
            if (i_end) begin
                i_pend  <= 1'b0;
                i_rdata <= abort ? DATA_W'(ARB_ABORT_DATA) : m_rdata;
            end
            if ((!i_pend || i_end) && i_rstrb) begin
                i_pend   <= 1'b1;
                i_addr_q <= i_addr;
            end
        end
    end

    // A simultaneous load and store strobe captures only the store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_pend    <= 1'b0;
            d_write_q <= 1'b0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            d_wmask_q <= '0;
            d_rdata   <= '0;
        end else begin
            if (d_end) begin
                d_pend <= 1'b0;
                if (!cur_write)
                    d_rdata <= abort ? DATA_W'(ARB_ABORT_DATA) : m_rdata;
            end
            if ((!d_pend || d_end) && (d_rstrb || d_wstrb)) begin
                d_pend    <= 1'b1;
                d_write_q <= d_wstrb;
                d_addr_q  <= d_addr;
                d_wdata_q <= d_wdata;
                d_wmask_q <= d_wmask;
            end
        end
    end

endmodule
